// File: rtl/ultrasonic_pkg.sv
// Shared constants for the ultrasonic ranging path. These are used by the HC-SR04 echo
// emulator and by distance_measurement: state encoding, timing constants and distance
// helpers.
package ultrasonic_pkg;

  // FSM state encoding
  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StTrigHigh = 3'd1;
  localparam logic [2:0] StBurst    = 3'd2;
  localparam logic [2:0] StEcho     = 3'd3;
  localparam logic [2:0] StHoldoff  = 3'd4;

  // Timing at 1 MHz, so one cycle is 1 us
  localparam logic [15:0] TRIG_MIN_CYCLES = 16'd10;
  localparam logic [15:0] BURST_CYCLES    = 16'd200;
  localparam logic [15:0] CYCLES_PER_CM   = 16'd58;
  localparam logic [15:0] TIMEOUT_CYCLES  = 16'd38000;
  localparam logic [15:0] HOLDOFF_CYCLES  = 16'd60000;

  // Valid distance range, inclusive
  localparam logic [8:0] MIN_CM = 9'd2;
  localparam logic [8:0] MAX_CM = 9'd400;

  // d * 58 without a multiplier: 64d - 4d - 2d. The largest 9-bit input fits in 16 bits.
  function automatic logic [15:0] cm_to_cycles(input logic [8:0] d);
    logic [15:0] w;
    w = {7'd0, d};
    return (w << 6) - (w << 2) - (w << 1);
  endfunction

  function automatic logic cm_in_range(input logic [8:0] d);
    return (d >= MIN_CM) && (d <= MAX_CM);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level. Resets to 0.
module sync_2ff (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Capture and re-time the asynchronous input
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 responder emulator. The trigger pulse is qualified and accepted on its fall. The
// block then waits a fixed burst delay and drives an echo whose width is 58 cycles per cm.
// An out-of-range distance gives a fixed timeout-width echo.
// Optional feature macro ECHO_EMU_HOLDOFF_EN: adds a post-echo retrigger lockout.
module hcsr04_echo_emulator
  import ultrasonic_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_trigger,
  input  logic [8:0] i_distance_cm,
  output logic       o_echo,
  output logic       o_busy,
  output logic       o_trig_err,
  output logic       o_out_of_range
);

  logic        w_trig_s;
  logic        w_trig_rise;
  logic        w_in_range;
  logic [15:0] w_width;

  logic        r_trig_prev;
  logic [2:0]  r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_width;
  logic        r_echo;
  logic        r_busy;
  logic        r_trig_err;
  logic        r_oor;

  logic [2:0]  w_state_nxt;
  logic [15:0] w_cnt_nxt;
  logic [15:0] w_width_nxt;
  logic        w_echo_nxt;
  logic        w_busy_nxt;
  logic        w_trig_err_nxt;
  logic        w_oor_nxt;

  sync_2ff u_trig_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (i_trigger),
    .o_q       (w_trig_s)
  );

  // A trigger that is still high on return to IDLE creates no rising edge here.
  // It must go low and then high again before it counts.
  assign w_trig_rise = w_trig_s & ~r_trig_prev;
  assign w_in_range  = cm_in_range(i_distance_cm);
  assign w_width     = w_in_range ? cm_to_cycles(i_distance_cm) : TIMEOUT_CYCLES;

  // Keep the previous synchronized trigger level for edge detection
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_trig_prev <= 1'b0;
    else            r_trig_prev <= w_trig_s;
  end

  // Next-state logic for trigger qualification, burst delay and echo timing
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_width_nxt    = r_width;
    w_echo_nxt     = r_echo;
    w_busy_nxt     = r_busy;
    w_trig_err_nxt = 1'b0;
    w_oor_nxt      = r_oor;
    case (r_state)
      StIdle: begin
        if (w_trig_rise) begin
          // The cycle that reveals the rise is the first high cycle, so it counts as one.
          w_state_nxt = StTrigHigh;
          w_cnt_nxt   = 16'd1;
        end
      end
      StTrigHigh: begin
        if (w_trig_s) begin
          if (r_cnt < TRIG_MIN_CYCLES) w_cnt_nxt = r_cnt + 16'd1;
        end else if (r_cnt >= TRIG_MIN_CYCLES) begin
          w_state_nxt = StBurst;
          w_cnt_nxt   = 16'd0;
          w_width_nxt = w_width;
          w_oor_nxt   = ~w_in_range;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt    = StIdle;
          w_cnt_nxt      = 16'd0;
          w_trig_err_nxt = 1'b1;
        end
      end
      StBurst: begin
        if (r_cnt == BURST_CYCLES - 16'd1) begin
          w_state_nxt = StEcho;
          w_cnt_nxt   = 16'd0;
          w_echo_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      StEcho: begin
        if (r_cnt == r_width - 16'd1) begin
          w_echo_nxt = 1'b0;
          w_cnt_nxt  = 16'd0;
`ifdef ECHO_EMU_HOLDOFF_EN
          w_state_nxt = StHoldoff;
`else
          w_state_nxt = StIdle;
          w_busy_nxt  = 1'b0;
          w_oor_nxt   = 1'b0;
`endif
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
`ifdef ECHO_EMU_HOLDOFF_EN
      StHoldoff: begin
        if (r_cnt == HOLDOFF_CYCLES - 16'd1) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = 16'd0;
          w_busy_nxt  = 1'b0;
          w_oor_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
`endif
      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = 16'd0;
        w_echo_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
        w_oor_nxt   = 1'b0;
      end
    endcase
  end

  // State and registered outputs. Reset drops the echo at once.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= StIdle;
      r_cnt      <= 16'd0;
      r_width    <= 16'd0;
      r_echo     <= 1'b0;
      r_busy     <= 1'b0;
      r_trig_err <= 1'b0;
      r_oor      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_width    <= w_width_nxt;
      r_echo     <= w_echo_nxt;
      r_busy     <= w_busy_nxt;
      r_trig_err <= w_trig_err_nxt;
      r_oor      <= w_oor_nxt;
    end
  end

  assign o_echo         = r_echo;
  assign o_busy         = r_busy;
  assign o_trig_err     = r_trig_err;
  assign o_out_of_range = r_oor;

endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
// Scoreboard bench for hcsr04_echo_emulator. Each trigger pushes its expected outcome.
// A negedge monitor pops and compares the outcome when the DUT reports an error pulse or
// completes an echo.
module tb_hcsr04_echo_emulator;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_trigger = 1'b0;
  logic [8:0] i_distance_cm = 9'd0;
  logic       o_echo;
  logic       o_busy;
  logic       o_trig_err;
  logic       o_out_of_range;

  hcsr04_echo_emulator dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_trigger      (i_trigger),
    .i_distance_cm  (i_distance_cm),
    .o_echo         (o_echo),
    .o_busy         (o_busy),
    .o_trig_err     (o_trig_err),
    .o_out_of_range (o_out_of_range)
  );

  always #5 i_clk = ~i_clk;

  int unsigned cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    int unsigned acc;    // cycle (negedge view) when busy rises or the error pulse shows
    int unsigned width;
    bit          oor;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void check(string name, longint act, longint req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference: 58 cycles per cm inside 2..400 cm, otherwise a 38000-cycle timeout echo
  function automatic int unsigned model_width(int unsigned d);
    return (d >= 2 && d <= 400) ? d * 58 : 38000;
  endfunction

  function automatic bit model_oor(int unsigned d);
    return !(d >= 2 && d <= 400);
  endfunction

  // Monitor
  bit          p_echo = 1'b0;
  bit          p_busy = 1'b0;
  int unsigned rise_c = 0;
  bit          rise_oor = 1'b0;
  exp_t        m_e;

  always @(negedge i_clk) begin
    if (!i_reset_n) begin
      p_echo = 1'b0;
      p_busy = 1'b0;
    end else begin
      if (o_busy && !p_busy) begin
        check("busy_rise_pending", q.size() > 0, 1);
        if (q.size() > 0) begin
          check("busy_rise_kind", q[0].is_err, 0);
          check("busy_rise_cycle", cyc, q[0].acc);
        end
      end
      if (o_trig_err) begin
        check("trig_err_pending", q.size() > 0, 1);
        if (q.size() > 0) begin
          m_e = q.pop_front();
          check("trig_err_kind", m_e.is_err, 1);
          check("trig_err_cycle", cyc, m_e.acc);
        end
      end
      if (o_echo && !p_echo) begin
        rise_c   = cyc;
        rise_oor = o_out_of_range;
        check("busy_at_echo_rise", o_busy, 1);
      end
      if (!o_echo && p_echo) begin
        check("echo_pending", q.size() > 0, 1);
        if (q.size() > 0) begin
          m_e = q.pop_front();
          check("echo_kind", m_e.is_err, 0);
          check("echo_rise_cycle", rise_c, m_e.acc + 200);
          check("echo_width", cyc - rise_c, m_e.width);
          check("out_of_range", rise_oor, m_e.oor);
        end
      end
      p_echo = o_echo;
      p_busy = o_busy;
    end
  end

  // Drive a trigger high for n cycles. Optionally record the expected outcome.
  task automatic pulse(int unsigned n, logic [8:0] d, bit push);
    exp_t e;
    @(negedge i_clk);
    i_distance_cm = d;
    i_trigger     = 1'b1;
    repeat (n) @(negedge i_clk);
    i_trigger = 1'b0;
    if (push) begin
      e.is_err = (n < 10);
      e.acc    = cyc + 3;
      e.width  = model_width(d);
      e.oor    = model_oor(d);
      q.push_back(e);
    end
  endtask

  task automatic wait_done();
    int unsigned t;
    t = 0;
    while ((q.size() != 0 || o_busy) && t < 110000) begin
      @(negedge i_clk);
      t++;
    end
    check("drain_in_time", t < 110000, 1);
    repeat (5) @(negedge i_clk);
  endtask

  initial begin
    int unsigned t;
    logic [8:0]  d;
    int unsigned n;

    repeat (3) @(negedge i_clk);
    check("reset_echo", o_echo, 0);
    check("reset_busy", o_busy, 0);
    check("reset_trig_err", o_trig_err, 0);
    check("reset_oor", o_out_of_range, 0);
    i_reset_n = 1'b1;
    repeat (3) @(negedge i_clk);

    pulse(10, 9'd100, 1'b1); wait_done();
    pulse(5, 9'd100, 1'b1);  wait_done();
    pulse(9, 9'd50, 1'b1);   wait_done();
    pulse(12, 9'd401, 1'b1); wait_done();
    pulse(10, 9'd2, 1'b1);   wait_done();
    pulse(10, 9'd400, 1'b1); wait_done();

    // Distance change during burst and a retrigger during echo are both ignored
    pulse(10, 9'd100, 1'b1);
    repeat (50) @(negedge i_clk);
    i_distance_cm = 9'd300;
    t = 0;
    while (!o_echo && t < 400) begin @(negedge i_clk); t++; end
    check("echo_rose", o_echo, 1);
    repeat (100) @(negedge i_clk);
    pulse(12, 9'd300, 1'b0);
    wait_done();

    // Reset in the middle of an out-of-range echo
    pulse(10, 9'd1, 1'b1);
    t = 0;
    while (!o_echo && t < 400) begin @(negedge i_clk); t++; end
    check("oor_echo_rose", o_echo, 1);
    check("oor_during_echo", o_out_of_range, 1);
    repeat (100) @(negedge i_clk);
    @(posedge i_clk);
    #3;
    i_reset_n = 1'b0;
    #1;
    check("reset_mid_echo_echo", o_echo, 0);
    check("reset_mid_echo_busy", o_busy, 0);
    check("reset_mid_echo_oor", o_out_of_range, 0);
    q.delete();
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (3) @(negedge i_clk);
    pulse(10, 9'd10, 1'b1); wait_done();

    // Random widths around the qualification threshold, short in-range distances
    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(20, 1);
      d = 9'($urandom_range(30, 2));
      pulse(n, d, 1'b1);
      wait_done();
    end

`ifdef ECHO_EMU_HOLDOFF_EN
    pulse(10, 9'd20, 1'b1);
    t = 0;
    while (q.size() != 0 && t < 2000) begin @(negedge i_clk); t++; end
    repeat (1000) @(negedge i_clk);
    pulse(12, 9'd20, 1'b0);
    repeat (5) @(negedge i_clk);
    check("holdoff_busy", o_busy, 1);
    wait_done();
    pulse(10, 9'd20, 1'b1);
    wait_done();
`endif

    check("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hcsr04_echo_emulator.md
# hcsr04_echo_emulator

Responder side of the ultrasonic ranging interface: emulates an HC-SR04 sensor so the distance-measurement and display path can run on-chip or in simulation without a physical sensor. It accepts a trigger pulse, qualifies it, waits a fixed burst delay, then drives an echo pulse whose width encodes a programmed distance at 58 cycles/cm (1 MHz clock, 1 µs/cycle). Out-of-range distances produce a fixed timeout-width echo.

## Interface
- TRIG_MIN_CYCLES, 10: minimum synchronized trigger high time for a valid trigger
- BURST_CYCLES, 200: delay from trigger acceptance to echo rise (emulated 8×40 kHz burst)
- CYCLES_PER_CM, 58: echo width per cm
- MIN_CM, 2 / MAX_CM, 400: valid distance range, inclusive
- TIMEOUT_CYCLES, 38000: echo width for an out-of-range distance
- HOLDOFF_CYCLES, 60000: post-echo retrigger lockout; used only with the holdoff macro
- i_clk  in  1  system clock, 1 MHz
- i_reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_trigger  in  1  trigger from the measurement block, asynchronous to i_clk
- i_distance_cm  in  9  emulated distance in cm, sampled at trigger acceptance
- o_echo  out  1  echo pulse, registered
- o_busy  out  1  high from trigger acceptance until return to IDLE
- o_trig_err  out  1  one-cycle pulse when a trigger shorter than TRIG_MIN_CYCLES is rejected
- o_out_of_range  out  1  high for the measurement in progress when the latched distance is outside MIN_CM..MAX_CM

## Operation
- i_trigger passes through a 2-FF synchronizer; the FSM sees only the synchronized signal trig_s.
- States: IDLE, TRIG_HIGH, BURST, ECHO, HOLDOFF (HOLDOFF only with macro).
- IDLE: trig_s rising -> TRIG_HIGH, width counter cleared.
- TRIG_HIGH: count cycles while trig_s high, saturating at TRIG_MIN_CYCLES. On trig_s low: count >= TRIG_MIN_CYCLES -> latch i_distance_cm, compute echo width, BURST; otherwise pulse o_trig_err, return to IDLE. Trigger held arbitrarily long is valid and is accepted on its fall.
- Width: d in MIN_CM..MAX_CM -> d*58 computed shift-add as (d<<6)-(d<<2)-(d<<1), 16-bit; otherwise TIMEOUT_CYCLES and o_out_of_range=1. d=0 is out of range.
- BURST: count BURST_CYCLES, then -> ECHO with o_echo=1.
- ECHO: o_echo high exactly width cycles, then o_echo=0 -> IDLE (or HOLDOFF).
- Triggers arriving in BURST, ECHO, HOLDOFF are ignored without error; a trigger still high on return to IDLE does not count until trig_s is seen low then high again.
- i_distance_cm changes after acceptance have no effect on the current echo.
- o_out_of_range and o_busy clear on return to IDLE.

## Timing
- Reset values: o_echo=0, o_busy=0, o_trig_err=0, o_out_of_range=0, state IDLE, all counters 0. Asserting reset mid-echo drops o_echo immediately (asynchronous).
- Trigger acceptance: 3 clocks after the first edge sampling i_trigger low (2 sync + FSM); o_busy rises then.
- o_echo rises BURST_CYCLES clocks after o_busy rises; stays high exactly width clocks.
- o_trig_err asserts on the same edge the short trigger is rejected, for one clock.
- Max counter value 60000 -> 16-bit counters.

## Configuration
- ECHO_EMU_HOLDOFF_EN defined: after echo falls, HOLDOFF for HOLDOFF_CYCLES with o_busy high, triggers ignored, then IDLE.
- Not defined: ECHO returns directly to IDLE; HOLDOFF state and its counter are absent; HOLDOFF_CYCLES unused.

## Structure
- Package ultrasonic_pkg: FSM state encoding, CYCLES_PER_CM, MIN_CM, MAX_CM, TIMEOUT_CYCLES, shared with distance_measurement.
- One sub-module: sync_2ff (2-FF synchronizer, async active-low reset to 0).

## Test plan
- Reset, trigger high 10 cycles, d=100 -> o_echo rises BURST_CYCLES+3 cycles after trigger fall, high exactly 5800 cycles, o_out_of_range=0.
- Trigger high 5 cycles -> single o_trig_err pulse, no echo, o_busy stays 0.
- d=401 and d=1 -> echo width 38000, o_out_of_range=1 during measurement; d=2 -> 116, d=400 -> 23200.
- d changed 100->300 mid-BURST, second trigger pulse mid-ECHO -> echo still 5800 cycles, no second echo, no o_trig_err.
- Reset asserted mid-ECHO -> o_echo low same instant; after release next valid trigger produces normal echo.
- With ECHO_EMU_HOLDOFF_EN: trigger 1000 cycles after echo fall ignored, o_busy high; trigger after 60000 cycles accepted.
